// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - branch/jump hazard controller: stalls ID-resolved branches behind EX/MEM producers
module branch_hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_branch,
  input  logic [1:0]       de_control,
  input  logic             cmp,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ext_stall,
  output logic             stall,
  output logic             bubble,
  output logic             pc_sel,
  output logic             jump_sel,
  output logic             flush_ifid,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL, RESOLVE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q;

  logic       branch, taken, ex_match, mem_match;
  logic [1:0] h;
  logic       stall_c, pc_c, jump_c, flush_c;

  assign branch    = id_branch & de_control[1];
  assign taken     = de_control[0] ~^ cmp;
  assign ex_match  = (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign mem_match = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

  // A load in EX needs two bubbles; an ALU result in EX or a load in MEM needs one.
  always_comb begin
    h = 2'd0;
    if (branch) begin
      if (ex_mem_read && ex_match)
        h = 2'd2;
      else if ((ex_reg_write && !ex_mem_read && ex_match) || (mem_mem_read && mem_match))
        h = 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    pc_c    = 1'b0;
    jump_c  = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (id_jump) begin
          jump_c  = 1'b1;
          flush_c = 1'b1;
        end else if (branch) begin
          if (h == 2'd0) begin
            pc_c    = taken;
            flush_c = taken;
          end else begin
            stall_c = 1'b1;
            if (h == 2'd2) begin
              state_d = STALL;
              cnt_d   = 2'd1;
            end else begin
              state_d = RESOLVE;
            end
          end
        end
      end
      STALL: begin
        stall_c = 1'b1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = RESOLVE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESOLVE: begin
        pc_c    = de_control[1] & taken;
        flush_c = de_control[1] & taken;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are gated by rst_n so they drop the instant reset asserts, not at the next edge.
  assign stall      = rst_n & stall_c;
  assign bubble     = rst_n & stall_c;
  assign pc_sel     = rst_n & ~ext_stall & pc_c;
  assign jump_sel   = rst_n & ~ext_stall & jump_c;
  assign flush_ifid = rst_n & ~ext_stall & flush_c;
  assign stall_cnt  = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else if (!ext_stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_c && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_branch  in  1  conditional branch in ID.
- de_control  in  2  [1] branch enable, [0] polarity (1 = taken when cmp=1, 0 = taken when cmp=0).
- cmp  in  1  ID equality-compare result, already forwarded.
- id_jump  in  1  unconditional jump in ID.
- id_rs, id_rt  in  REG_W  branch source registers.
- ex_reg_write, ex_mem_read  in  1  EX-stage instruction writes a register / is a load.
- ex_rd  in  REG_W  EX-stage destination.
- mem_mem_read  in  1  MEM-stage instruction is a load.
- mem_rd  in  REG_W  MEM-stage destination.
- ext_stall  in  1  global pipeline freeze (memory wait).
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert NOP into ID/EX.
- pc_sel  out  1  select branch target.
- jump_sel  out  1  select jump target.
- flush_ifid  out  1  squash IF/ID contents.
- stall_cnt  out  16  total branch-hazard stall cycles.

Function
REQ-003 SHALL treat register 0 as never hazardous.
REQ-004 SHALL compute hazard depth h combinationally for a branch (id_branch=1 and de_control[1]=1):
- h=2 if ex_mem_read and ex_rd matches id_rs or id_rt.
- h=1 if ex_reg_write, not ex_mem_read, and ex_rd matches.
- h=1 if mem_mem_read and mem_rd matches.
- Otherwise h=0; h is the maximum of all applicable cases.
REQ-005 SHALL implement FSM states RUN, STALL, RESOLVE, with a 2-bit down-counter cnt.
REQ-006 In RUN with branch and h=0: pc_sel = flush_ifid = (de_control[0] XNOR cmp); stay in RUN.
REQ-007 In RUN with branch and h>0: stall = bubble = 1, pc_sel = flush_ifid = 0.
- h=1: next state RESOLVE.
- h=2: next state STALL with cnt=1.
REQ-008 In STALL: stall = bubble = 1; cnt decrements; go to RESOLVE when cnt reaches 0 after the decrement.
REQ-009 In RESOLVE: stall = bubble = 0; pc_sel = flush_ifid = (de_control[0] XNOR cmp); next state RUN.
REQ-010 In RUN with id_jump=1: jump_sel = flush_ifid = 1, no stall; id_jump takes priority over id_branch in the same cycle.
REQ-011 SHALL hold jump_sel at 0 outside RUN.
REQ-012 When ext_stall=1: state, cnt and stall_cnt hold; pc_sel, jump_sel and flush_ifid are forced to 0; stall and bubble keep their state-derived values.
REQ-013 SHALL increment stall_cnt by 1 on every non-frozen cycle with stall=1, saturating at 0xFFFF.
REQ-014 SHALL never assert pc_sel and jump_sel in the same cycle.
REQ-015 SHALL never assert flush_ifid together with stall.
REQ-016 When de_control[1]=0, SHALL ignore id_branch: no stall, pc_sel=0.

Reset
REQ-017 SHALL, while rst_n=0, force state RUN, cnt=0, stall_cnt=0, and all 1-bit outputs 0, regardless of clk.
REQ-018 SHALL abandon any pending stall or resolve immediately on reset assertion mid-sequence; after reset, resume in RUN on the first rising edge with rst_n=1.

Verification
REQ-019 No hazard: branch with de_control=2'b11, cmp=1, h=0 -> pc_sel=1 and flush_ifid=1 in the same cycle; stall=0; stall_cnt unchanged.
REQ-020 ALU hazard: ex_reg_write=1, ex_rd=5, id_rs=5, de_control=2'b10, cmp=0 -> stall=1 for 1 cycle, then RESOLVE with pc_sel=1; stall_cnt=1.
REQ-021 Load hazard: ex_mem_read=1, ex_rd=7, id_rt=7 -> stall=bubble=1 for 2 cycles (RUN, STALL), then RESOLVE; with cmp=0 and de_control=2'b11, pc_sel=0 and flush_ifid=0; stall_cnt=2.
REQ-022 Register 0 and jump priority: ex_rd=0=id_rs -> no stall; id_jump=1 with id_branch=1 -> jump_sel=1, pc_sel=0, flush_ifid=1.
REQ-023 Freeze and reset: ext_stall=1 during STALL for 3 cycles -> state and stall_cnt hold, then stalling resumes; rst_n=0 pulse in STALL -> all outputs 0 asynchronously, stall_cnt=0.
REQ-024 Saturation: preload stall_cnt to 0xFFFE via stall cycles -> after 2 more stall cycles, stall_cnt=0xFFFF and holds.
